// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: mode encodings, counter reset value
// and the default-geometry BTB entry layout.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_STATIC  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 32;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX - 2;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
  } btb_entry_t;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int ctr_reset(int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One PHT entry: saturating up/down counter, reset to weakly not-taken.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] count
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset(CTR_BITS));

  always_ff @(posedge clk) begin
    if (reset)                        count <= CTR_RST;
    else if (inc && count != CTR_MAX) count <= count + 1'b1;
    else if (dec && count != '0)      count <= count - 1'b1;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: BTB plus PHT in static, bimodal or gshare mode,
// with a speculative GHR repaired from EX on mispredict.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 32,
  parameter int GHR_BITS = 5,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_valid,
  input  logic [XLEN-1:0]     if_pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [XLEN-1:0]     pred_next_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam bit ACTIVE = (MODE != int'(BP_STATIC));
  localparam bit GSHARE = (MODE == int'(BP_GSHARE));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t                             btb [ENTRIES];
  logic [ENTRIES-1:0][CTR_BITS-1:0]   ctr;
  logic [GHR_BITS-1:0]                ghr;
  logic [IDX-1:0]                     btb_idx, pht_idx, upd_idx, upd_pht_idx;
  logic                               hit, train;
  logic                               unused_bits;

  function automatic logic [IDX-1:0] pht_index(logic [IDX-1:0] idx, logic [GHR_BITS-1:0] h);
    return GSHARE ? (idx ^ IDX'(h)) : idx;
  endfunction

  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign btb_idx     = if_pc[IDX+1:2];
  assign pht_idx     = pht_index(btb_idx, ghr);
  assign upd_idx     = upd_pc[IDX+1:2];
  assign upd_pht_idx = pht_index(upd_idx, upd_ghr);
  assign train       = ACTIVE && upd_valid;

  assign hit          = btb[btb_idx].valid && (btb[btb_idx].tag == if_pc[XLEN-1:IDX+2]);
  assign pred_taken   = ACTIVE && hit && ctr[pht_idx][CTR_BITS-1];
  assign pred_target  = hit ? btb[btb_idx].target : '0;
  assign pred_next_pc = pred_taken ? pred_target : if_pc + XLEN'(4);
  assign pred_ghr     = ghr;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
    bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (train &&  upd_taken && upd_pht_idx == IDX'(i)),
      .dec   (train && !upd_taken && upd_pht_idx == IDX'(i)),
      .count (ctr[i])
    );
  end

  // Only taken outcomes allocate; a not-taken resolve leaves the entry alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (train && upd_taken) begin
      btb[upd_idx] <= '{valid: 1'b1, tag: upd_pc[XLEN-1:IDX+2], target: upd_target};
    end
  end

  // Repair beats the same-cycle speculative shift.
  always_ff @(posedge clk) begin
    if (reset || !GSHARE)              ghr <= '0;
    else if (upd_valid && upd_mispredict) ghr <= GHR_BITS'({upd_ghr, upd_taken});
    else if (if_valid && hit)          ghr <= GHR_BITS'({ghr, pred_taken});
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: static, bimodal and gshare instances share one stimulus stream.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset, if_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic [4:0]  upd_ghr;

  logic        s_taken, b_taken, g_taken;
  logic [31:0] s_target, b_target, g_target, s_next, b_next, g_next;
  logic [4:0]  s_ghr, b_ghr, g_ghr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(0)) u_sta (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(s_taken), .pred_target(s_target), .pred_next_pc(s_next), .pred_ghr(s_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict));

  branch_predictor #(.MODE(1)) u_bim (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(b_taken), .pred_target(b_target), .pred_next_pc(b_next), .pred_ghr(b_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict));

  branch_predictor #(.MODE(2)) u_gsh (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(g_taken), .pred_target(g_target), .pred_next_pc(g_next), .pred_ghr(g_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic [4:0] ghr, input logic misp);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_ghr = ghr; upd_mispredict = misp;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = 32'h100;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_ghr = '0; upd_mispredict = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_taken",  {31'b0, b_taken}, 32'h0);
    check("rst_target", b_target, 32'h0);
    check("rst_next",   b_next, 32'h104);
    check("rst_ghr",    {27'b0, g_ghr}, 32'h0);
    check("rst_gtaken", {31'b0, g_taken}, 32'h0);

    // bimodal: 01 -> 10 -> 11
    train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0);
    train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0);
    #1;
    check("bim_taken2",  {31'b0, b_taken}, 32'h1);
    check("bim_next2",   b_next, 32'h40);
    check("bim_target2", b_target, 32'h40);
    check("sta_taken",   {31'b0, s_taken}, 32'h0);
    check("sta_target",  s_target, 32'h0);

    train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);  // 10
    #1 check("bim_nt1", {31'b0, b_taken}, 32'h1);
    train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);  // 01
    #1;
    check("bim_nt2",        {31'b0, b_taken}, 32'h0);
    check("bim_nt2_next",   b_next, 32'h104);
    check("bim_nt2_target", b_target, 32'h40);

    // saturation high then low
    for (int i = 0; i < 5; i++) train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0);
    train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);  // 11 -> 10
    #1 check("sat_hi_nt1", {31'b0, b_taken}, 32'h1);
    train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);  // 01
    #1 check("sat_hi_nt2", {31'b0, b_taken}, 32'h0);
    for (int i = 0; i < 6; i++) train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);
    train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0); // 00 -> 01
    #1 check("sat_lo_t1", {31'b0, b_taken}, 32'h0);
    train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0); // 10
    #1 check("sat_lo_t2", {31'b0, b_taken}, 32'h1);

    // aliasing and wrap
    if_pc = 32'h180;
    #1;
    check("alias_taken",  {31'b0, b_taken}, 32'h0);
    check("alias_target", b_target, 32'h0);
    check("alias_next",   b_next, 32'h184);
    if_pc = 32'hFFFF_FFFC;
    #1 check("wrap_next", b_next, 32'h0);

    // same-cycle train/predict, no bypass
    if_pc = 32'h100;
    train(32'h100, 1'b0, 32'h0, 5'd0, 1'b0);  // 01
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h40;
    #1 check("same_cyc_pre", {31'b0, b_taken}, 32'h0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("same_cyc_post", {31'b0, b_taken}, 32'h1);
    check("ghr_hold_nofetch", {27'b0, g_ghr}, 32'h0);

    // reset mid-sequence overrides a concurrent update
    reset = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
    tick();
    reset = 1'b0; upd_valid = 1'b0;
    #1;
    check("rst_mid_taken",  {31'b0, b_taken}, 32'h0);
    check("rst_mid_target", b_target, 32'h0);
    check("rst_mid_next",   b_next, 32'h104);

    // gshare: make PHT entries 0,1,3 weakly taken for pc 0x100
    train(32'h100, 1'b1, 32'h40, 5'd0, 1'b0);
    train(32'h100, 1'b1, 32'h40, 5'd1, 1'b0);
    train(32'h100, 1'b1, 32'h40, 5'd3, 1'b0);
    if_valid = 1'b1;
    #1;
    check("gs_f1_ghr",   {27'b0, g_ghr}, 32'h0);
    check("gs_f1_taken", {31'b0, g_taken}, 32'h1);
    tick();
    check("gs_f2_ghr",   {27'b0, g_ghr}, 32'h1);
    check("gs_f2_taken", {31'b0, g_taken}, 32'h1);
    tick();
    check("gs_f3_ghr",   {27'b0, g_ghr}, 32'h3);
    check("gs_f3_taken", {31'b0, g_taken}, 32'h1);
    tick();
    if_valid = 1'b0;
    #1;
    check("gs_ghr_111", {27'b0, g_ghr}, 32'h7);
    check("bim_ghr",    {27'b0, b_ghr}, 32'h0);

    // repair wins over a same-cycle speculative fetch
    if_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b0; upd_ghr = 5'b00001; upd_mispredict = 1'b1;
    #1 check("gs_spec_taken", {31'b0, g_taken}, 32'h0);
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0; if_valid = 1'b0;
    #1 check("gs_repair", {27'b0, g_ghr}, 32'h2);
    tick();
    check("gs_stall_hold", {27'b0, g_ghr}, 32'h2);
    check("sta_ghr",       {27'b0, s_ghr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
